// File: rtl/ysyx_22041071_div_ctrl.sv
`default_nettype none
//==============================================================================
// Module   : ysyx_22041071_div_ctrl
// Brief    : RV64M DIV/REM controller; sequences an iterative divider, resolves
//            divide-by-zero and signed overflow locally, formats W results.
// Revision : 1.0 - initial release
//==============================================================================
module ysyx_22041071_div_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic        flush,
   input  logic        ex_valid,
   input  logic [2:0]  ex_op,
   input  logic [63:0] src1,
   input  logic [63:0] src2,
   output logic        ex_ready,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [63:0] result,
   output logic        div_valid,
   output logic        div_signed,
   output logic        divw,
   output logic [63:0] dividend,
   output logic [63:0] divisor,
   input  logic        div_ready,
   input  logic        div_out_valid,
   input  logic [63:0] div_quot,
   input  logic [63:0] div_rema
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_BUSY  = 2'd1,
      S_RESP  = 2'd2,
      S_DRAIN = 2'd3
   } state_t;

   localparam logic [63:0] C_ALL_ONES = {64{1'b1}};
   localparam logic [63:0] C_MIN64    = {1'b1, 63'd0};

   state_t      r_state, w_state_nxt;
   logic        r_pending, w_pending_nxt;
   logic [2:0]  r_op;
   logic [63:0] r_src1, r_src2, r_result;
   logic        w_accept, w_load, w_cap_spec, w_cap_div;
   logic        w_div_zero, w_ovf, w_special;
   logic [63:0] w_spec_raw, w_spec_res, w_div_raw, w_div_res;

   // A held op (divider was busy at accept) keeps the port closed until issue
   assign ex_ready   = (r_state == S_IDLE) && !r_pending;
   assign res_valid  = (r_state == S_RESP);
   assign div_valid  = (r_state == S_BUSY);
   assign div_signed = !r_op[1];
   assign divw       = r_op[2];
   assign dividend   = r_src1;
   assign divisor    = r_src2;
   assign result     = r_result;
   assign w_accept   = ex_valid && ex_ready && !flush;

   always_comb begin
      w_div_zero = ex_op[2] ? (src2[31:0] == 32'd0) : (src2 == 64'd0);
      w_ovf      = !ex_op[1] &&
                   (ex_op[2] ? (src1[31:0] == 32'h8000_0000 && src2[31:0] == 32'hFFFF_FFFF)
                             : (src1 == C_MIN64 && src2 == C_ALL_ONES));
      w_special  = w_div_zero || w_ovf;
      if (ex_op[0]) w_spec_raw = w_div_zero ? src1 : 64'd0;
      else          w_spec_raw = w_div_zero ? C_ALL_ONES : src1;
      w_spec_res = ex_op[2] ? {{32{w_spec_raw[31]}}, w_spec_raw[31:0]} : w_spec_raw;
      w_div_raw  = r_op[0] ? div_rema : div_quot;
      w_div_res  = r_op[2] ? {{32{w_div_raw[31]}}, w_div_raw[31:0]} : w_div_raw;
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_pending_nxt = r_pending;
      w_load        = 1'b0;
      w_cap_spec    = 1'b0;
      w_cap_div     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (flush) begin
               w_pending_nxt = 1'b0;
            end else if (r_pending) begin
               if (div_ready) begin
                  w_state_nxt   = S_BUSY;
                  w_pending_nxt = 1'b0;
               end
            end else if (w_accept) begin
               w_load = 1'b1;
               if (w_special) begin
                  w_state_nxt = S_RESP;
                  w_cap_spec  = 1'b1;
               end else if (div_ready) begin
                  w_state_nxt = S_BUSY;
               end else begin
                  w_pending_nxt = 1'b1;
               end
            end
         end
         S_BUSY: begin
            if (div_out_valid) begin
               if (flush) begin
                  w_state_nxt = S_IDLE;
               end else begin
                  w_state_nxt = S_RESP;
                  w_cap_div   = 1'b1;
               end
            end else if (flush) begin
               w_state_nxt = S_DRAIN;
            end
         end
         S_RESP: begin
            if (flush || res_ready) w_state_nxt = S_IDLE;
         end
         S_DRAIN: begin
            // Divider cannot be aborted; wait out its completion pulse
            if (div_out_valid) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= S_IDLE;
         r_pending <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_pending <= w_pending_nxt;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_op     <= 3'd0;
         r_src1   <= 64'd0;
         r_src2   <= 64'd0;
         r_result <= 64'd0;
      end else begin
         if (w_load) begin
            r_op   <= ex_op;
            r_src1 <= src1;
            r_src2 <= src2;
         end
         if (w_cap_spec)     r_result <= w_spec_res;
         else if (w_cap_div) r_result <= w_div_res;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22041071_div_ctrl.sv
`default_nettype none
//==============================================================================
// Module   : tb_ysyx_22041071_div_ctrl
// Brief    : Bench for the DIV/REM controller with a behavioural divider and
//            an RV64M reference scoreboard.
// Revision : 1.0 - initial release
//==============================================================================
module tb_ysyx_22041071_div_ctrl;

   localparam logic [2:0] OP_DIV = 3'b000, OP_REM = 3'b001, OP_DIVU = 3'b010, OP_REMU = 3'b011;
   localparam logic [2:0] OP_DIVW = 3'b100, OP_REMW = 3'b101, OP_DIVUW = 3'b110, OP_REMUW = 3'b111;
   localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

   logic        clk = 1'b0, reset = 1'b0, flush = 1'b0, ex_valid = 1'b0, res_ready = 1'b0;
   logic [2:0]  ex_op = 3'd0;
   logic [63:0] src1 = 64'd0, src2 = 64'd0;
   logic        ex_ready, res_valid, div_valid, div_signed, divw, div_ready, div_out_valid;
   logic [63:0] result, dividend, divisor, div_quot, div_rema;

   int n_chk = 0, n_pass = 0;

   always #5 clk = ~clk;

   ysyx_22041071_div_ctrl dut (
      .clk(clk), .reset(reset), .flush(flush), .ex_valid(ex_valid), .ex_op(ex_op),
      .src1(src1), .src2(src2), .ex_ready(ex_ready), .res_valid(res_valid),
      .res_ready(res_ready), .result(result), .div_valid(div_valid),
      .div_signed(div_signed), .divw(divw), .dividend(dividend), .divisor(divisor),
      .div_ready(div_ready), .div_out_valid(div_out_valid),
      .div_quot(div_quot), .div_rema(div_rema)
   );

   task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // RV64M architectural result, straight from the ISA rules
   function automatic logic [63:0] rv_ref(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
      logic [31:0] a32, b32, q32, r32, s32;
      logic [63:0] q, r;
      a32 = a[31:0];
      b32 = b[31:0];
      if (op[2]) begin
         if (b32 == 32'd0) begin
            q32 = 32'hFFFF_FFFF; r32 = a32;
         end else if (!op[1] && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
            q32 = a32; r32 = 32'd0;
         end else if (op[1]) begin
            q32 = a32 / b32; r32 = a32 % b32;
         end else begin
            q32 = $signed(a32) / $signed(b32); r32 = $signed(a32) % $signed(b32);
         end
         s32 = op[0] ? r32 : q32;
         return {{32{s32[31]}}, s32};
      end
      if (b == 64'd0) begin
         q = ONES; r = a;
      end else if (!op[1] && a == MIN64 && b == ONES) begin
         q = a; r = 64'd0;
      end else if (op[1]) begin
         q = a / b; r = a % b;
      end else begin
         q = $signed(a) / $signed(b); r = $signed(a) % $signed(b);
      end
      return op[0] ? r : q;
   endfunction

   // Behavioural divider: fixed latency, junk in the upper word for W results
   logic        dbusy = 1'b0, dov = 1'b0, block = 1'b0;
   int          dcnt = 0, div_lat = 4;
   logic [63:0] dq = 64'd0, dr = 64'd0, d_a = 64'd0, d_b = 64'd0;
   assign div_ready     = !dbusy && !block;
   assign div_out_valid = dov;
   assign div_quot      = dq;
   assign div_rema      = dr;

   function automatic logic [63:0] junk_hi(input logic w, input logic [63:0] x);
      return w ? {32'hDEAD_BEEF, x[31:0]} : x;
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         dbusy <= 1'b0; dov <= 1'b0; dcnt <= 0;
      end else begin
         dov <= 1'b0;
         if (!dbusy) begin
            if (div_valid && div_ready) begin
               dbusy <= 1'b1;
               dcnt  <= div_lat;
               d_a   <= dividend;
               d_b   <= divisor;
               dq    <= junk_hi(divw, rv_ref({divw, !div_signed, 1'b0}, dividend, divisor));
               dr    <= junk_hi(divw, rv_ref({divw, !div_signed, 1'b1}, dividend, divisor));
            end
         end else if (dcnt > 1) dcnt <= dcnt - 1;
         else if (dcnt == 1) begin dov <= 1'b1; dcnt <= 0; end
         else dbusy <= 1'b0;
      end
   end

   // Scoreboard: one outstanding op, cancelled by flush, retired by res handshake
   logic        m_out = 1'b0, m_cancel = 1'b0, prev_dov = 1'b0;
   logic [63:0] m_exp = 64'd0;
   int          dv_cnt = 0;

   always @(negedge clk) begin
      if (!reset) begin
         m_out = 1'b0; prev_dov = 1'b0;
      end else begin
         if (res_valid) begin
            check(m_out && !m_cancel, "sb_res_owner", {63'd0, m_cancel}, 64'd0);
            check(result === m_exp, "sb_result", result, m_exp);
            check(!ex_ready, "sb_no_accept_in_resp", {63'd0, ex_ready}, 64'd0);
         end
         if (prev_dov) check(!div_valid, "sb_no_restart", {63'd0, div_valid}, 64'd0);
         if (dbusy) check(dividend === d_a && divisor === d_b, "sb_operands_stable", dividend, d_a);
         dv_cnt  += int'(div_valid);
         prev_dov = dov;
         if (flush) m_cancel = 1'b1;
         if (res_valid && res_ready) m_out = 1'b0;
         if (ex_valid && ex_ready && !flush) begin
            m_out = 1'b1; m_cancel = 1'b0; m_exp = rv_ref(ex_op, src1, src2);
         end
      end
   end

   task automatic drive_accept(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                               input string name, output int dv0);
      int k;
      @(posedge clk); #1;
      ex_op = op; src1 = a; src2 = b; ex_valid = 1'b1;
      k = 0;
      do begin @(negedge clk); k++; end while (!(ex_ready && !flush) && k < 100);
      if (k >= 100) check(1'b0, {name, "_accept_timeout"}, 64'd0, 64'd1);
      @(posedge clk); #1;
      ex_valid = 1'b0;
      dv0 = dv_cnt;
   endtask

   task automatic wait_res(input string name, output int cyc);
      cyc = 0;
      do begin @(negedge clk); cyc++; end while (!res_valid && cyc < 200);
      if (!res_valid) check(1'b0, {name, "_res_timeout"}, 64'd0, 64'd1);
   endtask

   task automatic release_res(input string name);
      @(posedge clk); #1 res_ready = 1'b1;
      @(posedge clk); #1 res_ready = 1'b0;
      @(negedge clk);
      check(!res_valid && ex_ready, {name, "_idle_after"}, {62'd0, res_valid, ex_ready}, 64'd1);
   endtask

   task automatic run_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] lit, input int lat_exp, input bit via_div,
                         input int hold, input string name);
      int dv0, cyc;
      drive_accept(op, a, b, name, dv0);
      wait_res(name, cyc);
      if (lat_exp > 0) check(cyc == lat_exp, {name, "_latency"}, 64'(cyc), 64'(lat_exp));
      check(result === lit, {name, "_result"}, result, lit);
      check((dv_cnt > dv0) == via_div, {name, "_div_used"}, 64'(dv_cnt - dv0), {63'd0, via_div});
      repeat (hold) begin
         @(negedge clk);
         check(res_valid && !ex_ready && result === lit, {name, "_hold"}, result, lit);
      end
      release_res(name);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int dv0, cyc, bad, k;
      repeat (2) @(negedge clk);
      check(!res_valid && !div_valid && ex_ready, "reset_flags", {61'd0, res_valid, div_valid, ex_ready}, 64'd1);
      check(result === 64'd0 && dividend === 64'd0 && divisor === 64'd0, "reset_data", result | dividend | divisor, 64'd0);
      @(posedge clk); #1 reset = 1'b1;

      run_op(OP_DIV,   64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 0, 1'b1, 0, "div_m7_2");
      run_op(OP_REM,   64'hFFFF_FFFF_FFFF_FFF9, 64'd2, ONES,                    0, 1'b1, 0, "rem_m7_2");
      run_op(OP_DIVU,  64'd5, 64'd0, ONES,  1, 1'b0, 0, "divu_by0");
      run_op(OP_REMU,  64'd5, 64'd0, 64'd5, 1, 1'b0, 0, "remu_by0");
      run_op(OP_DIV,   MIN64, ONES, MIN64,  1, 1'b0, 0, "div_ovf");
      run_op(OP_REM,   MIN64, ONES, 64'd0,  1, 1'b0, 0, "rem_ovf");
      run_op(OP_DIVW,  64'h0000_0000_8000_0000, ONES, 64'hFFFF_FFFF_8000_0000, 1, 1'b0, 0, "divw_ovf");
      run_op(OP_REMUW, 64'd7, 64'd2, 64'd1, 0, 1'b1, 0, "remuw_7_2");
      run_op(OP_DIVW,  64'h1234_5678_FFFF_FFF0, 64'hABCD_0000_0000_0003, 64'hFFFF_FFFF_FFFF_FFFB, 0, 1'b1, 0, "divw_m16_3");
      run_op(OP_REMW,  64'h1234_5678_FFFF_FFF0, 64'hABCD_0000_0000_0003, ONES, 0, 1'b1, 0, "remw_m16_3");
      run_op(OP_DIVUW, 64'h0000_0000_FFFF_FFF0, 64'd1, 64'hFFFF_FFFF_FFFF_FFF0, 0, 1'b1, 0, "divuw_sext");
      run_op(OP_DIVUW, 64'h0000_0000_8000_0000, ONES, 64'd0, 0, 1'b1, 0, "divuw_no_ovf");
      run_op(OP_REMW,  64'h0000_0000_8000_0005, 64'h0000_0001_0000_0000, 64'hFFFF_FFFF_8000_0005, 1, 1'b0, 0, "remw_by0_lo");
      run_op(OP_DIVU,  64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 64'h5555_5555_5555_5554, 0, 1'b1, 0, "divu_big");
      run_op(OP_REMU,  64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 64'd2, 0, 1'b1, 0, "remu_big");
      run_op(OP_DIV,   64'd100, 64'd7, 64'd14, 0, 1'b1, 5, "div_backpressure");

      // Divider busy at accept: op is held, port closed, then issued
      block = 1'b1;
      drive_accept(OP_DIV, 64'd100, 64'd7, "held", dv0);
      bad = 0;
      repeat (4) begin @(negedge clk); if (ex_ready || div_valid || res_valid) bad++; end
      check(bad == 0, "held_waits", 64'(bad), 64'd0);
      @(posedge clk); #1 block = 1'b0;
      wait_res("held", cyc);
      check(result === 64'd14, "held_result", result, 64'd14);
      release_res("held");

      // Flush while a bypassed result is waiting
      drive_accept(OP_DIVU, 64'd5, 64'd0, "flush_resp", dv0);
      wait_res("flush_resp", cyc);
      @(posedge clk); #1 flush = 1'b1;
      @(posedge clk); #1 flush = 1'b0;
      @(negedge clk);
      check(!res_valid && ex_ready, "flush_resp_dropped", {62'd0, res_valid, ex_ready}, 64'd1);

      // Flush mid-divide: drain until the divider finishes, no response
      div_lat = 20;
      drive_accept(OP_DIV, 64'd100, 64'd7, "flush_busy", dv0);
      repeat (10) @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk); #1 flush = 1'b0;
      bad = 0; k = 0;
      do begin
         @(negedge clk); k++;
         if (res_valid || ex_ready || div_valid) bad++;
      end while (!div_out_valid && k < 100);
      check(k < 100 && bad == 0, "drain_quiet", 64'(bad), 64'd0);
      @(negedge clk);
      check(ex_ready && !res_valid, "drain_exit", {62'd0, res_valid, ex_ready}, 64'd1);
      div_lat = 4;
      run_op(OP_DIVU, 64'd100, 64'd7, 64'd14, 0, 1'b1, 0, "divu_after_drain");

      // Asynchronous reset mid-divide, then accept on the first edge after release
      div_lat = 10;
      drive_accept(OP_DIV, 64'd100, 64'd7, "reset_mid", dv0);
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      #1;
      check(!res_valid && !div_valid && ex_ready, "async_reset_flags", {61'd0, res_valid, div_valid, ex_ready}, 64'd1);
      check(result === 64'd0 && dividend === 64'd0 && divisor === 64'd0, "async_reset_data", result | dividend | divisor, 64'd0);
      @(posedge clk); #1;
      reset = 1'b1; ex_op = OP_DIV; src1 = MIN64; src2 = ONES; ex_valid = 1'b1;
      @(posedge clk); #1 ex_valid = 1'b0;
      @(negedge clk);
      check(res_valid && result === MIN64, "first_edge_accept", result, MIN64);
      release_res("first_edge");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
